// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin arbiter sharing one Sync_FIFO write port among NREQ producers.
// Each grant carries up to MAX_BURST accepted beats and never writes while the FIFO is full.
`timescale 1ns/1ps
module fifo_rr_write_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          req_ack,
  input  logic                     fifo_full,
  output logic                     fifo_write_en,
  output logic [DW-1:0]            fifo_data_in,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [OW-1:0] LAST_REQ  = OW'(NREQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic [0:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic [OW-1:0] winner;
  logic [OW-1:0] owner_next;
  logic          found;
  logic          accept;
  logic          burst_done;
  logic [DW-1:0] req_data_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_data_a[g] = req_data[g*DW +: DW];
  end

  // Two-pass priority search: indices at or above rr_ptr first, then wrap to 0.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    found  = 1'b0;
    winner = rr_ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (OW'(i) >= rr_ptr_q)) begin
        found  = 1'b1;
        winner = OW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        found  = 1'b1;
        winner = OW'(i);
      end
    end
  end

  assign owner_next = (owner_q == LAST_REQ) ? '0 : owner_q + 1'b1;

  // Write path is purely combinational from registered state, so an async reset
  // silences it within the same cycle.
  always_comb begin
    busy          = (state_q == BURST);
    accept        = busy & req[owner_q] & ~fifo_full;
    fifo_write_en = accept;
    req_ack       = accept ? (NREQ'(1) << owner_q) : '0;
    fifo_data_in  = busy ? req_data_a[owner_q] : '0;
    burst_done    = (accept && (beat_cnt_q == LAST_BEAT)) || !req[owner_q];
  end

  assign owner = owner_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          owner_d    = winner;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (burst_done) begin
          state_d    = IDLE;
          rr_ptr_d   = owner_next;
          beat_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
